// File: rtl/mdu_issue_ctrl.sv
// rtl/mdu_issue_ctrl.sv - RV32M issue/sequencing controller in front of a multi-cycle mul/div unit
// Optional last-result cache: define MDU_RESULT_REUSE_EN.
module mdu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             req_valid,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_rs1,
  input  logic [WIDTH-1:0] req_rs2,
  input  logic             flush,
  output logic             stall,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             mc_start,
  output logic [1:0]       mc_op,
  output logic [WIDTH-1:0] mc_op1,
  output logic [WIDTH-1:0] mc_op2,
  input  logic             mc_busy,
  input  logic [WIDTH-1:0] mc_result1,
  input  logic [WIDTH-1:0] mc_result2
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t state;
  logic   sel_hi;
  logic   neg_fixup;

  logic             accept;
  logic             is_div;
  logic             div_zero;
  logic             div_ovf;
  logic             bypass;
  logic             hi_in;
  logic             neg_in;
  logic [1:0]       op_in;
  logic [WIDTH-1:0] op1_in;
  logic [WIDTH-1:0] bypass_data;

  // Select the requested word from the 64-bit unit result, undoing the |rs1| trick for MULHSU.
  function automatic logic [WIDTH-1:0] pick(input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                                            input logic neg, input logic hi);
    logic [2*WIDTH-1:0] full;
    full = {r2, r1};
    if (neg) full = -full;
    return hi ? full[2*WIDTH-1:WIDTH] : full[WIDTH-1:0];
  endfunction

  always_comb begin
    is_div   = req_funct3[2];
    div_zero = is_div && (req_rs2 == '0);
    div_ovf  = is_div && !req_funct3[0] && (req_rs1 == MIN_NEG) && (req_rs2 == ALL_ONES);
    bypass   = div_zero || div_ovf;
    hi_in    = is_div ? req_funct3[1] : (req_funct3[1:0] != 2'b00);
    neg_in   = (req_funct3 == 3'b010) && req_rs1[WIDTH-1];
    if (is_div) op_in = {1'b1, req_funct3[0]};
    else        op_in = (req_funct3[1:0] == 2'b01) ? 2'b00 : 2'b01;
    op1_in   = neg_in ? -req_rs1 : req_rs1;
    if (div_zero) bypass_data = hi_in ? req_rs1 : ALL_ONES;
    else          bypass_data = hi_in ? '0 : MIN_NEG;
    accept   = (state == IDLE) && req_valid && !mc_busy && !flush;
  end

`ifdef MDU_RESULT_REUSE_EN
  logic             cache_valid;
  logic [1:0]       cache_op;
  logic [WIDTH-1:0] cache_op1;
  logic [WIDTH-1:0] cache_op2;
  logic             cache_neg;
  logic [WIDTH-1:0] cache_r1;
  logic [WIDTH-1:0] cache_r2;
  logic             cache_hit;

  // Keyed on issued operands: |rs1| plus the fixup flag identifies rs1 uniquely.
  assign cache_hit = cache_valid && (cache_op == op_in) && (cache_op1 == op1_in) &&
                     (cache_op2 == req_rs2) && (cache_neg == neg_in);
`endif

  assign mc_start   = (state == ISSUE);
  assign stall      = (state == ISSUE) || (state == WAIT) || (state == DRAIN) ||
                      ((state == IDLE) && req_valid);
  assign resp_valid = (state == DONE) && !flush;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= IDLE;
      mc_op     <= 2'b00;
      mc_op1    <= '0;
      mc_op2    <= '0;
      resp_data <= '0;
      sel_hi    <= 1'b0;
      neg_fixup <= 1'b0;
`ifdef MDU_RESULT_REUSE_EN
      cache_valid <= 1'b0;
      cache_op    <= 2'b00;
      cache_op1   <= '0;
      cache_op2   <= '0;
      cache_neg   <= 1'b0;
      cache_r1    <= '0;
      cache_r2    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mc_op     <= op_in;
            mc_op1    <= op1_in;
            mc_op2    <= req_rs2;
            sel_hi    <= hi_in;
            neg_fixup <= neg_in;
            if (bypass) begin
              resp_data <= bypass_data;
              state     <= DONE;
            end
`ifdef MDU_RESULT_REUSE_EN
            else if (cache_hit) begin
              resp_data <= pick(cache_r1, cache_r2, neg_in, hi_in);
              state     <= DONE;
            end
`endif
            else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= flush ? DRAIN : WAIT;
        WAIT: begin
          if (flush) begin
            state <= DRAIN;
          end else if (!mc_busy) begin
            resp_data <= pick(mc_result1, mc_result2, neg_fixup, sel_hi);
            state     <= DONE;
`ifdef MDU_RESULT_REUSE_EN
            cache_valid <= 1'b1;
            cache_op    <= mc_op;
            cache_op1   <= mc_op1;
            cache_op2   <= mc_op2;
            cache_neg   <= neg_fixup;
            cache_r1    <= mc_result1;
            cache_r2    <= mc_result2;
`endif
          end
        end
        DRAIN: if (!mc_busy) state <= IDLE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef MDU_RESULT_REUSE_EN
      if (flush) cache_valid <= 1'b0;
`endif
    end
  end

endmodule
